// File: rtl/period_meter_pkg.sv
// -----------------------------------------------------------------------------
// period_meter_pkg
//   Shared types and helpers for the period meter block.
//   - state_t    : measurement FSM state encoding (2 bits).
//   - sat_value  : all-ones saturation constant for a counter of a given width.
// -----------------------------------------------------------------------------
package period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,   // counter held at zero, waiting for enable
        ST_ARMED   = 2'd1,   // enabled, waiting for the first tick
        ST_MEASURE = 2'd2    // counting cycles between consecutive ticks
    } state_t;

    // Largest value representable in 'width' bits. Widths of 64 or more
    // clamp to the full 64-bit all-ones value.
    function automatic logic [63:0] sat_value(input int unsigned width);
        if (width >= 64) begin
            return '1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage : period_meter_pkg

// File: rtl/period_meter_sat_counter.sv
// -----------------------------------------------------------------------------
// period_meter_sat_counter
//   Up-counter that saturates at all-ones instead of wrapping.
//
//   Ports:
//     clk_in     in   system clock, rising edge
//     reset_in   in   asynchronous active-high reset (count -> 0)
//     clear      in   synchronous clear to 0 (highest priority)
//     load_one   in   synchronous load of 1 (starts a new interval)
//     increment  in   count up by one unless already saturated
//     count      out  current count
//     saturated  out  count is at all-ones
// -----------------------------------------------------------------------------
module period_meter_sat_counter
    import period_meter_pkg::*;
#(
    parameter int COUNTER_WIDTH = 26
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     clear,
    input  logic                     load_one,
    input  logic                     increment,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     saturated
);

    localparam logic [COUNTER_WIDTH-1:0] SAT_COUNT =
        COUNTER_WIDTH'(sat_value(COUNTER_WIDTH));

    assign saturated = (count == SAT_COUNT);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load_one) begin
            // The tick cycle itself is the first cycle of the new interval.
            count <= COUNTER_WIDTH'(1);
        end else if (increment && !saturated) begin
            count <= count + COUNTER_WIDTH'(1);
        end
    end

endmodule : period_meter_sat_counter

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//   Measures the number of clk_in cycles between consecutive tick strobes and
//   presents each result through a one-entry valid/ready output register.
//
//   Optional build macro: PERIOD_METER_EDGE_DETECT_EN
//     undefined : every cycle with tick_in high is a tick event (latency 1).
//     defined   : tick_in is registered and only a rising edge is a tick
//                 event, so a held-high level counts once (latency 2).
//
//   Ports:
//     clk_in        in   system clock, rising edge
//     reset_in      in   asynchronous active-high reset
//     enable_in     in   measurement enable; low returns to IDLE
//     tick_in       in   tick strobe, synchronous to clk_in
//     period_out    out  last captured period in clk_in cycles
//     valid_out     out  period_out holds an unconsumed result
//     ready_in      in   consumer accepts when valid_out && ready_in
//     overflow_out  out  captured period saturated (qualifies period_out)
//     overrun_out   out  sticky: a result was dropped because the register
//                        was still full; cleared by reset or enable falling
// -----------------------------------------------------------------------------
module period_meter
    import period_meter_pkg::*;
#(
    parameter int COUNTER_WIDTH = 26
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     enable_in,
    input  logic                     tick_in,
    output logic [COUNTER_WIDTH-1:0] period_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic                     overflow_out,
    output logic                     overrun_out
);

    // -------------------------------------------------------------------------
    // Tick event generation
    // -------------------------------------------------------------------------
    logic tick_event;

`ifdef PERIOD_METER_EDGE_DETECT_EN
    logic tick_cur;
    logic tick_prev;

    // Both stages reset to 0, so a tick_in held high through reset release
    // shows up as a rising edge once it has passed through tick_cur.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            tick_cur  <= 1'b0;
            tick_prev <= 1'b0;
        end else begin
            tick_cur  <= tick_in;
            tick_prev <= tick_cur;
        end
    end

    assign tick_event = tick_cur && !tick_prev;
`else
    assign tick_event = tick_in;
`endif

    // -------------------------------------------------------------------------
    // Period counter
    // -------------------------------------------------------------------------
    logic                     cnt_clear;
    logic                     cnt_load_one;
    logic                     cnt_increment;
    logic [COUNTER_WIDTH-1:0] cnt_value;
    logic                     cnt_saturated;

    period_meter_sat_counter #(
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_counter (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .clear     (cnt_clear),
        .load_one  (cnt_load_one),
        .increment (cnt_increment),
        .count     (cnt_value),
        .saturated (cnt_saturated)
    );

    // -------------------------------------------------------------------------
    // Measurement FSM: state register
    // -------------------------------------------------------------------------
    state_t state;
    state_t state_next;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Measurement FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output is given a default before any branch
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (!enable_in) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_next = ST_ARMED;
                ST_ARMED:   if (tick_event) state_next = ST_MEASURE;
                ST_MEASURE: state_next = ST_MEASURE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Measurement FSM: output logic (counter control and capture strobe)
    // -------------------------------------------------------------------------
    logic capture;

    always_comb begin
        cnt_clear     = 1'b0;
        cnt_load_one  = 1'b0;
        cnt_increment = 1'b0;
        capture       = 1'b0;
        if (!enable_in) begin
            // Leaving for IDLE: any partial count is discarded.
            cnt_clear = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_clear = 1'b1;
                end
                ST_ARMED: begin
                    // First tick only starts an interval; no result.
                    cnt_load_one = tick_event;
                end
                ST_MEASURE: begin
                    // A tick both ends this interval and starts the next,
                    // so no cycle is lost between measurements.
                    capture       = tick_event;
                    cnt_load_one  = tick_event;
                    cnt_increment = !tick_event;
                end
                default: begin
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Enable history, used to spot the 1->0 transition that clears overrun
    // -------------------------------------------------------------------------
    logic enable_prev;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            enable_prev <= 1'b0;
        end else begin
            enable_prev <= enable_in;
        end
    end

    // -------------------------------------------------------------------------
    // One-entry output register
    // -------------------------------------------------------------------------
    logic handshake;
    logic can_load;

    assign handshake = valid_out && ready_in;
    // The register can accept a capture if it is empty or is being drained
    // in this very cycle.
    assign can_load  = !valid_out || ready_in;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            period_out   <= '0;
            overflow_out <= 1'b0;
            valid_out    <= 1'b0;
            overrun_out  <= 1'b0;
        end else begin
            if (capture && can_load) begin
                period_out   <= cnt_value;
                overflow_out <= cnt_saturated;
                valid_out    <= 1'b1;
            end else if (capture) begin
                // Register full and not draining: drop the new result.
                overrun_out <= 1'b1;
            end else if (handshake) begin
                valid_out <= 1'b0;
            end

            // Capture needs enable_in high, so this never races the set above.
            if (enable_prev && !enable_in) begin
                overrun_out <= 1'b0;
            end
        end
    end

endmodule : period_meter

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
//   Self-checking bench for period_meter (default build). Two instances share
//   all inputs: a 26-bit meter and a 4-bit meter whose small range makes
//   saturation easy to reach. A timestamp-based reference model predicts
//   every output every cycle; directed steps cover the named scenarios and a
//   randomized phase follows.
// -----------------------------------------------------------------------------
module tb_period_meter;

    localparam int W_WIDE   = 26;
    localparam int W_NARROW = 4;

    logic clk_in = 1'b0;
    logic reset_in;
    logic enable_in;
    logic tick_in;
    logic ready_in;

    logic [W_WIDE-1:0]   period_w;
    logic                valid_w;
    logic                overflow_w;
    logic                overrun_w;
    logic [W_NARROW-1:0] period_n;
    logic                valid_n;
    logic                overflow_n;
    logic                overrun_n;

    always #5 clk_in = ~clk_in;

    period_meter #(.COUNTER_WIDTH(W_WIDE)) dut_wide (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .enable_in    (enable_in),
        .tick_in      (tick_in),
        .period_out   (period_w),
        .valid_out    (valid_w),
        .ready_in     (ready_in),
        .overflow_out (overflow_w),
        .overrun_out  (overrun_w)
    );

    period_meter #(.COUNTER_WIDTH(W_NARROW)) dut_narrow (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .enable_in    (enable_in),
        .tick_in      (tick_in),
        .period_out   (period_n),
        .valid_out    (valid_n),
        .ready_in     (ready_in),
        .overflow_out (overflow_n),
        .overrun_out  (overrun_n)
    );

    int checks = 0;
    int errors = 0;

    // ---------------------------------------------------------------------
    // Reference model: tracks the cycle number of the last tick event and
    // computes each period as a difference of timestamps.
    // Index 0 = wide instance, index 1 = narrow instance.
    // ---------------------------------------------------------------------
    longint cycle       = 0;
    bit     prev_en     = 1'b0;   // enable seen at the previous edge
    bit     have_start  = 1'b0;   // an interval start timestamp exists
    longint start_cycle = 0;
    bit     m_valid  [2];
    longint m_period [2];
    bit     m_ovf    [2];
    bit     m_ovr    [2];

    function automatic longint sat_of(input int k);
        return (k == 0) ? ((longint'(1) << W_WIDE) - 1) : ((longint'(1) << W_NARROW) - 1);
    endfunction

    task automatic model_reset();
        prev_en    = 1'b0;
        have_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_valid[k]  = 1'b0;
            m_period[k] = 0;
            m_ovf[k]    = 1'b0;
            m_ovr[k]    = 1'b0;
        end
    endtask

    // Called once per rising edge with the inputs the DUT sampled there.
    task automatic model_step();
        bit     cap;
        longint d;
        cycle++;
        if (reset_in) begin
            model_reset();
            return;
        end
        cap = 1'b0;
        d   = 0;
        // The meter only listens once enable has been high for a full cycle
        // (one cycle is spent leaving IDLE).
        if (enable_in && prev_en && tick_in) begin
            if (have_start) begin
                cap = 1'b1;
                d   = cycle - start_cycle;
            end
            have_start  = 1'b1;
            start_cycle = cycle;
        end
        if (!enable_in) have_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (cap) begin
                if (!m_valid[k] || ready_in) begin
                    m_valid[k]  = 1'b1;
                    m_period[k] = (d > sat_of(k)) ? sat_of(k) : d;
                    m_ovf[k]    = (d >= sat_of(k));
                end else begin
                    m_ovr[k] = 1'b1;
                end
            end else if (m_valid[k] && ready_in) begin
                m_valid[k] = 1'b0;
            end
            if (prev_en && !enable_in) m_ovr[k] = 1'b0;
        end
        prev_en = enable_in;
    endtask

    // ---------------------------------------------------------------------
    // Checking helpers
    // ---------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_against_model();
        check($sformatf("w_period@%0d", cycle),   64'(period_w),   64'(m_period[0]));
        check($sformatf("w_valid@%0d", cycle),    64'(valid_w),    64'(m_valid[0]));
        check($sformatf("w_overflow@%0d", cycle), 64'(overflow_w), 64'(m_ovf[0]));
        check($sformatf("w_overrun@%0d", cycle),  64'(overrun_w),  64'(m_ovr[0]));
        check($sformatf("n_period@%0d", cycle),   64'(period_n),   64'(m_period[1]));
        check($sformatf("n_valid@%0d", cycle),    64'(valid_n),    64'(m_valid[1]));
        check($sformatf("n_overflow@%0d", cycle), 64'(overflow_n), 64'(m_ovf[1]));
        check($sformatf("n_overrun@%0d", cycle),  64'(overrun_n),  64'(m_ovr[1]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_w_period"},   64'(period_w),   64'd0);
        check({tag, "_w_valid"},    64'(valid_w),    64'd0);
        check({tag, "_w_overflow"}, 64'(overflow_w), 64'd0);
        check({tag, "_w_overrun"},  64'(overrun_w),  64'd0);
        check({tag, "_n_period"},   64'(period_n),   64'd0);
        check({tag, "_n_valid"},    64'(valid_n),    64'd0);
        check({tag, "_n_overflow"}, 64'(overflow_n), 64'd0);
        check({tag, "_n_overrun"},  64'(overrun_n),  64'd0);
    endtask

    // One clock: inputs already set; advance the model at the edge, then
    // compare shortly after the edge.
    task automatic step();
        @(posedge clk_in);
        model_step();
        #1;
        check_against_model();
    endtask

    task automatic hold(input int n);
        tick_in = 1'b0;
        repeat (n) step();
    endtask

    task automatic tick_once();
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Directed and randomized stimulus
    // ---------------------------------------------------------------------
    initial begin
        reset_in  = 1'b1;
        enable_in = 1'b0;
        tick_in   = 1'b0;
        ready_in  = 1'b0;
        model_reset();

        // Reset state
        #3;
        check_all_zero("reset");
        step();
        step();
        reset_in = 1'b0;

        // Basic period: ticks 100 cycles apart, consumer always ready
        enable_in = 1'b1;
        ready_in  = 1'b1;
        step();                       // leaves IDLE
        hold(3);
        tick_once();                  // arms only
        check("arm_no_result", 64'(valid_w), 64'd0);
        hold(99);
        tick_once();
        check("basic1_valid",    64'(valid_w),    64'd1);
        check("basic1_period",   64'(period_w),   64'd100);
        check("basic1_overflow", 64'(overflow_w), 64'd0);
        hold(99);
        tick_once();
        check("basic2_valid",  64'(valid_w),  64'd1);
        check("basic2_period", 64'(period_w), 64'd100);

        // Back-to-back tick cycles: each following high cycle yields 1
        hold(20);
        tick_in = 1'b1;
        step();
        check("b2b_first", 64'(period_w), 64'd21);
        step();
        check("b2b_second", 64'(period_w), 64'd1);
        step();
        check("b2b_third", 64'(period_w), 64'd1);
        tick_in = 1'b0;

        // Saturation: 40-cycle interval overflows the 4-bit meter
        hold(39);
        tick_once();
        check("sat_n_period",   64'(period_n),   64'd15);
        check("sat_n_overflow", 64'(overflow_n), 64'd1);
        check("sat_w_period",   64'(period_w),   64'd40);
        hold(4);
        tick_once();
        check("after_sat_n_period",   64'(period_n),   64'd5);
        check("after_sat_n_overflow", 64'(overflow_n), 64'd0);

        // Backpressure: consumer stalls, second result is dropped
        step();                       // drains the result of 5
        ready_in = 1'b0;
        hold(18);
        tick_once();                  // interval 20
        check("bp_first_period", 64'(period_w), 64'd20);
        hold(29);
        tick_once();                  // interval 30, dropped
        check("bp_kept_period", 64'(period_w),  64'd20);
        check("bp_overrun",     64'(overrun_w), 64'd1);
        check("bp_still_valid", 64'(valid_w),   64'd1);
        hold(2);
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        check("bp_drained", 64'(valid_w), 64'd0);
        hold(3);
        tick_once();                  // interval 7
        check("bp_next_period", 64'(period_w), 64'd7);
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;

        // Enable dropped mid-interval: overrun clears, first tick only arms
        hold(4);
        enable_in = 1'b0;
        step();
        check("en_low_overrun_cleared", 64'(overrun_w), 64'd0);
        hold(3);
        enable_in = 1'b1;
        step();
        hold(4);
        tick_once();
        check("rearm_no_result", 64'(valid_w), 64'd0);

        // Simultaneous handshake and capture
        hold(9);
        tick_once();                  // interval 10, held unconsumed
        hold(11);
        ready_in = 1'b1;
        tick_once();                  // interval 12 lands as 10 drains
        check("simul_valid",   64'(valid_w),   64'd1);
        check("simul_period",  64'(period_w),  64'd12);
        check("simul_overrun", 64'(overrun_w), 64'd0);
        step();
        check("simul_drain", 64'(valid_w), 64'd0);

        // Asynchronous reset 5 cycles into an interval
        hold(5);
        tick_once();                  // leave a result pending
        ready_in = 1'b0;
        hold(5);
        #2;
        reset_in = 1'b1;
        #1;
        check_all_zero("async_reset");
        step();
        step();
        reset_in = 1'b0;

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            tick_in  = ($urandom_range(0, 7) == 0);
            ready_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) enable_in = ~enable_in;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_period_meter
